mult_product_accumulator: RTL
=============================

Name: mult_product_accumulator

Overview:
- Sequential stage directly downstream of two_bit_multiplier: consumes its 4-bit product p through a valid/ready handshake.
- Sums a fixed-length frame of COUNT products into a wider accumulator, then presents the frame sum and a sticky overflow flag through an output valid/ready handshake.
- Sits between the combinational multiplier array and any consumer needing dot-product style results.

Parameters:
- PROD_W, 4, width of incoming product (matches two_bit_multiplier p).
- COUNT, 4, number of products per frame; legal range 2..255.
- ACC_W, 6, accumulator/result width; must be >= PROD_W.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  product on in_p is valid.
- in_ready  output  1  block can accept a product this cycle.
- in_p  input  PROD_W  product from two_bit_multiplier.
- out_valid  output  1  frame result is valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  frame sum, modulo 2^ACC_W.
- out_ovf  output  1  any carry out of ACC_W occurred during the frame.
- busy  output  1  at least one product accepted in the current, unfinished frame.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=ACCUM, acc=0, cnt=0, ovf=0; outputs in_ready=1, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- States: ACCUM and DONE.
- ACCUM behaviour:
  - in_ready=1.
  - A transfer occurs when in_valid&in_ready at a rising edge.
  - On each transfer: acc <= acc + zero-extended in_p, truncated to ACC_W bits. ovf <= ovf | carry-out of that add.
  - If cnt < COUNT-1, cnt increments.
  - If cnt == COUNT-1: go to DONE and register out_sum = final acc and out_ovf = final ovf.
- Latency: out_valid asserts on the cycle after the COUNT-th transfer.
- DONE behaviour:
  - in_ready=0 and out_valid=1.
  - out_sum and out_ovf are held stable until the handshake.
  - On out_valid&out_ready: clear acc, cnt and ovf; return to ACCUM. in_ready=1 on the next cycle.
  - No same-cycle pass-through: the earliest restart is the cycle after the output handshake.
- in_valid low in ACCUM: no change; gaps between products are allowed.
- in_p is ignored when no transfer occurs; X on in_p without in_valid must not corrupt state.
- out_ready is ignored in ACCUM.
- busy = (state==ACCUM) && (cnt != 0).
- Reset mid-frame or while in DONE: the partial sum and any pending result are discarded; all values return to reset values on the next edge.
- out_valid must never drop without an out_ready handshake, except on rst.
- Wrap-around: the sum wraps modulo 2^ACC_W and ovf is sticky for the frame.
- cnt width is clog2(COUNT).

Decomposition:
- Shared package mult_pkg:
  - PROD_W constant shared with two_bit_multiplier.
  - State enum/localparams ST_ACCUM=1'b0, ST_DONE=1'b1.
  - Default COUNT and ACC_W constants.
- One natural sub-module: frame_counter (mod-COUNT counter with an enable input and a terminal-count output).
- The datapath add and FSM stay in the top level.

Test Plan:
- Reset, then 4 products 9,6,3,2 with in_valid held high -> out_valid on the cycle after the 4th transfer; out_sum=20, out_ovf=0; in_ready=0 until out_ready.
- Same frame with in_valid gaps (high every 3rd cycle) and out_ready held low 5 cycles -> out_sum=20 held stable all 5 cycles; next frame's first product is accepted only the cycle after the handshake.
- ACC_W=5, products 9,9,9,9 -> out_sum=4 (36 mod 32), out_ovf=1; the next frame 1,1,1,1 -> out_sum=4, out_ovf=0 (sticky flag cleared).
- Assert rst after 2 products (9,9), then send 1,2,3,4 -> out_sum=10, out_ovf=0, busy=0 right after reset.
- Assert rst while in DONE with out_valid=1 -> out_valid=0 and in_ready=1 on the next edge; out_sum=0.
- Back-to-back frames with out_ready tied high, driven by two_bit_multiplier inputs (3×1, 2×3, 3×3, 1×1) -> out_sum=19 for each frame; exactly one idle input cycle between frames.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the multiplier product path.
package mult_pkg;

  localparam int PKG_PROD_W = 4;  // width of two_bit_multiplier product p
  localparam int PKG_COUNT  = 4;
  localparam int PKG_ACC_W  = 6;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/frame_counter.sv
// Purpose: mod-COUNT product counter with terminal-count flag.
// Latency: tc is a decode of the registered count, same cycle.
// Backpressure: advances only when en is high; clr wins over en.
module frame_counter #(
  parameter int COUNT = 4,
  parameter int CW    = $clog2(COUNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mult_product_accumulator.sv
// Purpose: sums COUNT products per frame, reports sum plus sticky carry flag.
// Latency: result valid the cycle after the COUNT-th accepted product.
// Backpressure: input stalls (in_ready=0) while a result awaits out_ready.
module mult_product_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = PKG_PROD_W,
  parameter int COUNT  = PKG_COUNT,
  parameter int ACC_W  = PKG_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam int CW = $clog2(COUNT);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             xfer;
  logic             release_res;
  logic [ACC_W:0]   sum;

  assign xfer        = (state == ST_ACCUM) && in_valid;
  assign release_res = (state == ST_DONE) && out_ready;
  // Extra MSB of the add captures the carry out of the accumulator width.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_p};

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_ACCUM) && (cnt != '0);

  frame_counter #(
    .COUNT(COUNT),
    .CW   (CW)
  ) u_frame_counter (
    .clk(clk),
    .rst(rst),
    .clr(release_res),
    .en (xfer),
    .cnt(cnt),
    .tc (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACCUM;
      acc     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (xfer) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
            if (tc) begin
              state   <= ST_DONE;
              out_sum <= sum[ACC_W-1:0];
              out_ovf <= ovf | sum[ACC_W];
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_ACCUM;
            acc   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule
